// File: rtl/zephyr_cosim_mbox.sv
// zephyr_cosim_mbox: per-channel request FIFOs merged onto one registered output by a
// round-robin arbiter; a beat stalled too long is dropped and flagged per channel.
module zephyr_cosim_mbox #(
  parameter int NUM_CHAN = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 255,
  localparam int CHAN_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_CHAN-1:0]        req_valid,
  output logic [NUM_CHAN-1:0]        req_ready,
  input  logic [NUM_CHAN*DATA_W-1:0] req_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CHAN_W-1:0]          out_chan,
  input  logic [NUM_CHAN-1:0]        err_clr,
  output logic [NUM_CHAN-1:0]        timeout_err,
  output logic                       irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [15:0]      STALL_LIMIT = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  logic [DATA_W-1:0] mem_q    [NUM_CHAN][DEPTH];
  logic [DATA_W-1:0] mem_d    [NUM_CHAN][DEPTH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CHAN];
  logic [CNT_W-1:0]  cnt_d    [NUM_CHAN];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CHAN];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CHAN];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CHAN];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CHAN];

  logic [NUM_CHAN-1:0] full, nonempty, push, pop;

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CHAN_W-1:0]   out_chan_q, out_chan_d;
  logic [CHAN_W-1:0]   last_grant_q, last_grant_d;
  logic [15:0]         stall_q, stall_d;
  logic [NUM_CHAN-1:0] err_q, err_d;

  logic [CHAN_W-1:0] grant, cand;
  logic              grant_found;
  logic              stalled, handshake, load, drop;

  // Ready is forced high while in reset so upstream never sees stale fullness.
  always_comb begin
    for (int i = 0; i < NUM_CHAN; i++) begin
      full[i]      = (cnt_q[i] == FULL_CNT);
      nonempty[i]  = (cnt_q[i] != '0);
      req_ready[i] = !full[i] || !reset_n;
      push[i]      = req_valid[i] && req_ready[i] && reset_n;
    end
  end

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      cand = CHAN_W'((int'(last_grant_q) + 1 + k) % NUM_CHAN);
      if (!grant_found && nonempty[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  assign stalled   = out_valid_q && !out_ready;
  assign handshake = out_valid_q && out_ready;
  assign drop      = (TIMEOUT != 0) && stalled && (stall_q == STALL_LIMIT);
  assign load      = (!out_valid_q || out_ready) && grant_found;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_CHAN; i++) begin
      pop[i]      = load && (grant == CHAN_W'(i));
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = req_data[i*DATA_W +: DATA_W];
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  // A load always wins over a pending timeout since it only happens when not stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;
    err_d        = err_q & ~err_clr;
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = mem_q[grant][rd_ptr_q[grant]];
      out_chan_d   = grant;
      last_grant_d = grant;
      stall_d      = '0;
    end else if (handshake) begin
      out_valid_d = 1'b0;
      stall_d     = '0;
    end else if (drop) begin
      out_valid_d       = 1'b0;
      stall_d           = '0;
      err_d[out_chan_q] = 1'b1;
    end else if (stalled && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      last_grant_q <= CHAN_W'(NUM_CHAN - 1);
      stall_q      <= '0;
      err_q        <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        cnt_q[i]    <= cnt_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
      err_q        <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_chan    = out_chan_q;
  assign timeout_err = err_q;
  assign irq         = |err_q;

endmodule

// File: tb/tb_zephyr_cosim_mbox.sv
// tb_zephyr_cosim_mbox: table-driven cycle vectors plus scoreboarded sequences for
// round-robin order, backpressure, and reset in mid-operation.
module tb_zephyr_cosim_mbox;

  localparam int NUM_CHAN = 4;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 8;
  localparam int CHAN_W   = 2;

  logic                       clock = 1'b0;
  logic                       reset_n;
  logic [NUM_CHAN-1:0]        req_valid;
  logic [NUM_CHAN-1:0]        req_ready;
  logic [NUM_CHAN*DATA_W-1:0] req_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [CHAN_W-1:0]          out_chan;
  logic [NUM_CHAN-1:0]        err_clr;
  logic [NUM_CHAN-1:0]        timeout_err;
  logic                       irq;

  zephyr_cosim_mbox #(
    .NUM_CHAN(NUM_CHAN), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .err_clr(err_clr), .timeout_err(timeout_err), .irq(irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ready;
    logic [3:0]  clr;
    logic        exp_valid;
    logic [1:0]  exp_chan;
    logic [31:0] exp_data;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_err;
  } vec_t;

  typedef struct {
    logic [1:0]  chan;
    logic [31:0] data;
  } beat_t;

  vec_t  vecs[$];
  beat_t expQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;
  int    beatsSeen = 0;
  bit    sbOn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard: a handshake is seen just before the edge that completes it.
  task automatic tick();
    beat_t e;
    if (sbOn && reset_n && out_valid && out_ready) begin
      beatsSeen++;
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL sb_unexpected: got chan %0d data %h, expected no beat", out_chan, out_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_chan", 32'(out_chan), 32'(e.chan));
        checkOutput("sb_data", out_data, e.data);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic addRow(input logic rst_n, input logic [3:0] valid, input logic [31:0] data,
                        input logic ready, input logic [3:0] clr, input logic ev,
                        input logic [1:0] ech, input logic [31:0] edata, input logic [3:0] eerr);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.data = data; v.ready = ready; v.clr = clr;
    v.exp_valid = ev; v.exp_chan = ech; v.exp_data = edata; v.exp_ready = 4'hF; v.exp_err = eerr;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset_n   = v.rst_n;
    req_valid = v.valid;
    req_data  = {4{v.data}};
    out_ready = v.ready;
    err_clr   = v.clr;
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    err_clr   = '0;
    tick();
    expQ.delete();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    reset_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0; err_clr = '0;

    // Single beat, timeout, set/clear collision and handshake-beats-timeout, cycle by cycle.
    addRow(0, 4'b0000, 32'h0,         1, 4'b0000, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b0100, 32'hA5A5_0001, 1, 4'b0000, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b0000, 32'h0,         1, 4'b0000, 1, 2, 32'hA5A5_0001, 4'b0000);
    addRow(1, 4'b0000, 32'h0,         1, 4'b0000, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b0010, 32'h0000_1111, 0, 4'b0000, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b0000, 32'h0,         0, 4'b0000, 1, 1, 32'h0000_1111, 4'b0000);
    for (int i = 0; i < 7; i++)
      addRow(1, 4'b0000, 32'h0, 0, 4'b0000, 1, 1, 32'h0000_1111, 4'b0000);
    addRow(1, 4'b0000, 32'h0,         0, 4'b0000, 0, 0, 32'h0,         4'b0010);
    addRow(1, 4'b0000, 32'h0,         0, 4'b0010, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b0000, 32'h0,         0, 4'b0000, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b0010, 32'h0000_2222, 0, 4'b0000, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b0000, 32'h0,         0, 4'b0000, 1, 1, 32'h0000_2222, 4'b0000);
    for (int i = 0; i < 7; i++)
      addRow(1, 4'b0000, 32'h0, 0, 4'b0000, 1, 1, 32'h0000_2222, 4'b0000);
    addRow(1, 4'b0000, 32'h0,         0, 4'b0010, 0, 0, 32'h0,         4'b0010);
    addRow(1, 4'b0000, 32'h0,         0, 4'b0010, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b1000, 32'h0000_3333, 0, 4'b0000, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b0000, 32'h0,         0, 4'b0000, 1, 3, 32'h0000_3333, 4'b0000);
    for (int i = 0; i < 7; i++)
      addRow(1, 4'b0000, 32'h0, 0, 4'b0000, 1, 3, 32'h0000_3333, 4'b0000);
    addRow(1, 4'b0000, 32'h0,         1, 4'b0000, 0, 0, 32'h0,         4'b0000);
    addRow(1, 4'b0000, 32'h0,         1, 4'b0000, 0, 0, 32'h0,         4'b0000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("row%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("row%0d_chan", i), 32'(out_chan), 32'(vecs[i].exp_chan));
        checkOutput($sformatf("row%0d_data", i), out_data, vecs[i].exp_data);
      end
      checkOutput($sformatf("row%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("row%0d_err", i), 32'(timeout_err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("row%0d_irq", i), 32'(irq), 32'(|vecs[i].exp_err));
    end

    // Round-robin: two beats per channel, then drain at full rate.
    sbOn = 1'b1;
    doReset();
    for (int n = 0; n < 2; n++) begin
      beat_t b;
      req_valid = '1;
      for (int c = 0; c < NUM_CHAN; c++) begin
        req_data[c*DATA_W +: DATA_W] = 32'hC0DE_0000 + 32'(c * 16 + n);
        b.chan = 2'(c);
        b.data = 32'hC0DE_0000 + 32'(c * 16 + n);
        expQ.push_back(b);
      end
      tick();
    end
    req_valid = '0;
    base = beatsSeen;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("rr_valid%0d", i), 32'(out_valid), 32'd1);
      tick();
    end
    checkOutput("rr_valid_end", 32'(out_valid), 32'd0);
    checkOutput("rr_beats", 32'(beatsSeen - base), 32'd8);
    checkOutput("rr_queue_left", 32'(expQ.size()), 32'd0);

    // Backpressure: four beats in the FIFO plus one in the output register.
    doReset();
    base = beatsSeen;
    for (int n = 0; n < 5; n++) begin
      beat_t b;
      req_valid = 4'b0001;
      req_data[31:0] = 32'hBEEF_0000 + 32'(n);
      b.chan = 2'd0;
      b.data = 32'hBEEF_0000 + 32'(n);
      expQ.push_back(b);
      tick();
    end
    checkOutput("bp_ready_full", 32'(req_ready[0]), 32'd0);
    checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
    req_data[31:0] = 32'hDEAD_DEAD;
    tick();
    checkOutput("bp_ready_still_full", 32'(req_ready[0]), 32'd0);
    checkOutput("bp_data_stable", out_data, 32'hBEEF_0000);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_ready_after_pop", 32'(req_ready[0]), 32'd1);
    req_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("bp_valid_end", 32'(out_valid), 32'd0);
    checkOutput("bp_beats", 32'(beatsSeen - base), 32'd5);
    checkOutput("bp_queue_left", 32'(expQ.size()), 32'd0);

    // Reset while a beat is held and a FIFO is partly full.
    doReset();
    req_valid = 4'b1010;
    req_data[1*DATA_W +: DATA_W] = 32'h1111_0001;
    req_data[3*DATA_W +: DATA_W] = 32'h3333_0001;
    tick();
    req_valid = 4'b1000;
    req_data[3*DATA_W +: DATA_W] = 32'h3333_0002;
    tick();
    checkOutput("mid_valid_pre", 32'(out_valid), 32'd1);
    checkOutput("mid_chan_pre", 32'(out_chan), 32'd1);
    reset_n = 1'b0;
    req_data[3*DATA_W +: DATA_W] = 32'hDEAD_0003;
    #1;
    checkOutput("mid_ready_in_reset", 32'(req_ready), 32'hF);
    tick();
    checkOutput("mid_valid_rst", 32'(out_valid), 32'd0);
    checkOutput("mid_data_rst", out_data, 32'd0);
    checkOutput("mid_chan_rst", 32'(out_chan), 32'd0);
    checkOutput("mid_err_rst", 32'(timeout_err), 32'd0);
    checkOutput("mid_irq_rst", 32'(irq), 32'd0);
    reset_n = 1'b1;
    req_valid = '0;
    expQ.delete();
    checkOutput("mid_ready_release", 32'(req_ready), 32'hF);
    base = beatsSeen;
    out_ready = 1'b1;
    req_valid = 4'b0101;
    req_data[0*DATA_W +: DATA_W] = 32'h0000_AAAA;
    req_data[2*DATA_W +: DATA_W] = 32'h2222_0009;
    begin
      beat_t b;
      b.chan = 2'd0; b.data = 32'h0000_AAAA; expQ.push_back(b);
      b.chan = 2'd2; b.data = 32'h2222_0009; expQ.push_back(b);
    end
    tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("mid_valid_end", 32'(out_valid), 32'd0);
    checkOutput("mid_beats", 32'(beatsSeen - base), 32'd2);
    checkOutput("mid_queue_left", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
